// File: rtl/ff2_sync_pkg.sv
// Shared constants for the ff2_sync_p multi-flop synchronizer family.
// Holds the legal synchronizer depth range and the default depth.
package ff2_sync_pkg;

  localparam int SYNC_STAGES_MIN     = 2;
  localparam int SYNC_STAGES_MAX     = 4;
  localparam int SYNC_STAGES_DEFAULT = 2;

  function automatic bit stages_legal(input int stages);
    return (stages >= SYNC_STAGES_MIN) && (stages <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/ff2_sync_p_chain.sv
// Single-bit STAGES-deep synchronizer chain (module sync_bit_chain).
// The first flop catches the asynchronous level; later flops let it settle.
module sync_bit_chain
  import ff2_sync_pkg::*;
#(
  parameter int   STAGES      = SYNC_STAGES_DEFAULT,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  // Keep the capture flop next to its successor so metastability can resolve.
  (* ASYNC_REG = "TRUE" *) logic r_meta;
  logic [STAGES-2:0] r_tail;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RESET_VALUE;
      r_tail <= {(STAGES-1){RESET_VALUE}};
    end else begin
      r_meta    <= i_d;
      r_tail[0] <= r_meta;
      for (int i = 1; i < STAGES - 1; i++) begin
        r_tail[i] <= r_tail[i-1];
      end
    end
  end

  assign o_q = r_tail[STAGES-2];

endmodule

// File: rtl/ff2_sync_p.sv
// Multi-bit level synchronizer: WIDTH independent STAGES-deep chains into clk.
// Define FF2SYNCP_EDGE_DETECT_EN to add the rise/fall pulse outputs and history flop.
module ff2_sync_p
  import ff2_sync_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = SYNC_STAGES_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] in,
  input  logic             clk,
  output logic [WIDTH-1:0] out,
  input  logic             rst
`ifdef FF2SYNCP_EDGE_DETECT_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);

  if (!stages_legal(STAGES)) begin : g_bad_stages
    $error("ff2_sync_p: STAGES must be between 2 and 4");
  end

  logic [WIDTH-1:0] w_sync;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    sync_bit_chain #(
      .STAGES      (STAGES),
      .RESET_VALUE (RESET_VALUE[g])
    ) u_chain (
      .i_clk (clk),
      .i_rst (rst),
      .i_d   (in[g]),
      .o_q   (w_sync[g])
    );
  end

  assign out = w_sync;

`ifdef FF2SYNCP_EDGE_DETECT_EN
  // History loads RESET_VALUE with the chain so reset release never fakes an edge.
  logic [WIDTH-1:0] r_hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= RESET_VALUE;
    end else begin
      r_hist <= w_sync;
    end
  end

  assign rise = w_sync & ~r_hist;
  assign fall = ~w_sync & r_hist;
`endif

endmodule

// File: tb/tb_ff2_sync_p.sv
// Self-checking bench for ff2_sync_p: 4-bit/2-stage and 1-bit/3-stage instances.
// rise/fall are checked only when FF2SYNCP_EDGE_DETECT_EN is defined.
module tb_ff2_sync_p;

  logic       clk;
  logic       rst;
  logic [3:0] in_v;
  logic [3:0] out4;
  logic       out1;
  logic [3:0] rise4, fall4;
  logic       rise1, fall1;

  int checks;
  int errors;
  bit check_en;

  logic       rst_log[$];
  logic [3:0] in_log[$];

  ff2_sync_p #(.WIDTH(4), .STAGES(2), .RESET_VALUE(4'h0)) dut (
    .in   (in_v),
    .clk  (clk),
    .out  (out4),
    .rst  (rst)
`ifdef FF2SYNCP_EDGE_DETECT_EN
    ,
    .rise (rise4),
    .fall (fall4)
`endif
  );

  ff2_sync_p #(.WIDTH(1), .STAGES(3), .RESET_VALUE(1'b0)) dut3 (
    .in   (in_v[0]),
    .clk  (clk),
    .out  (out1),
    .rst  (rst)
`ifdef FF2SYNCP_EDGE_DETECT_EN
    ,
    .rise (rise1),
    .fall (fall1)
`endif
  );

`ifndef FF2SYNCP_EDGE_DETECT_EN
  assign rise4 = '0;
  assign fall4 = '0;
  assign rise1 = 1'b0;
  assign fall1 = 1'b0;
`endif

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model input log: what the chain saw at each rising edge.
  always @(posedge clk) begin
    rst_log.push_back(rst);
    in_log.push_back(in_v);
  end

  // Level after edge n: the input captured STAGES-1 edges earlier, unless a
  // reset edge falls inside that window, in which case the reset value.
  function automatic logic [3:0] exp_out(int n, int st);
    for (int k = 0; k < st; k++) begin
      if (n - k < 0) return 4'h0;
      if (rst_log[n-k]) return 4'h0;
    end
    return in_log[n-st+1];
  endfunction

  function automatic logic [3:0] exp_hist(int n, int st);
    if (n < 1 || rst_log[n]) return 4'h0;
    return exp_out(n - 1, st);
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare, on the falling edge away from capture
  always @(negedge clk) begin
    int n;
    logic [3:0] e2, e3, h2, h3;
    n = rst_log.size() - 1;
    if (check_en && n >= 3) begin
      e2 = exp_out(n, 2);
      e3 = exp_out(n, 3);
      chk("model_out4", out4, e2);
      chk("model_out1", {3'b0, out1}, {3'b0, e3[0]});
`ifdef FF2SYNCP_EDGE_DETECT_EN
      h2 = exp_hist(n, 2);
      h3 = exp_hist(n, 3);
      chk("model_rise4", rise4, e2 & ~h2);
      chk("model_fall4", fall4, ~e2 & h2);
      chk("model_rise1", {3'b0, rise1}, {3'b0, e3[0] & ~h3[0]});
      chk("model_fall1", {3'b0, fall1}, {3'b0, ~e3[0] & h3[0]});
`else
      h2 = '0;
      h3 = '0;
`endif
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_edges(input string name, input logic [3:0] r, input logic [3:0] f);
`ifdef FF2SYNCP_EDGE_DETECT_EN
    chk({name, "_rise"}, rise4, r);
    chk({name, "_fall"}, fall4, f);
`endif
  endtask

  logic [3:0] vec[8];
  int lat;

  initial begin
    checks   = 0;
    errors   = 0;
    check_en = 1'b1;
    vec = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h5, 4'hA, 4'h5, 4'hC};
    rst  = 1'b1;
    in_v = 4'hF;

    // reset held three edges with in=1
    step(); step(); step();
    chk("reset_out4", out4, 4'h0);
    chk("reset_out1", {3'b0, out1}, 4'h0);
    chk_edges("reset", 4'h0, 4'h0);

    rst = 1'b0;
    step();
    chk("release_e1_out4", out4, 4'h0);
    chk_edges("release_e1", 4'h0, 4'h0);
    step();
    chk("release_e2_out4", out4, 4'hF);
    chk("lat3_e2_out1", {3'b0, out1}, 4'h0);
    chk_edges("release_e2", 4'hF, 4'h0);
    step();
    chk("lat3_e3_out1", {3'b0, out1}, 4'h1);
    chk_edges("release_e3", 4'h0, 4'h0);

    // falling edge
    in_v = 4'h0;
    step();
    chk("fall_e1_out4", out4, 4'hF);
    step();
    chk("fall_e2_out4", out4, 4'h0);
    chk_edges("fall_e2", 4'h0, 4'hF);
    step();
    chk_edges("fall_e3", 4'h0, 4'h0);

    // multi-bit pattern
    in_v = 4'b1010;
    step();
    step();
    chk("multi_out4", out4, 4'b1010);
    chk_edges("multi", 4'b1010, 4'h0);
    step();
    chk_edges("multi_after", 4'h0, 4'h0);

    // reset one edge after capture
    in_v = 4'h0;
    step(); step();
    in_v = 4'hF;
    step();
    rst = 1'b1;
    step();
    chk("midrst_e1_out4", out4, 4'h0);
    step();
    chk("midrst_e2_out4", out4, 4'h0);
    rst = 1'b0;
    step();
    chk("midrst_rel1_out4", out4, 4'h0);
    step();
    chk("midrst_rel2_out4", out4, 4'hF);

    // directed vector table, including every-cycle toggling
    foreach (vec[i]) begin
      in_v = vec[i];
      step();
    end
    in_v = 4'h0;
    step(); step(); step();

    // asynchronous stimulus: short pulse between edges, then a held level
    check_en = 1'b0;
    #2 in_v = 4'hF;
    #3 in_v = 4'h0;
    step();
    #2 in_v = 4'hA;
    lat = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out4 === 4'hA) break;
    end
    checks++;
    if (out4 !== 4'hA || lat < 2 || lat > 3) begin
      errors++;
      $display("FAIL async_latency: got out=%h after %0d edges expected A within 2..3", out4, lat);
    end
    step(); step(); step();
    check_en = 1'b1;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
